// File: rtl/sr_pkg.sv
// Shared constants for the SR flop bank: conflict-resolution mode encodings
// and the popcount width helper.
package sr_pkg;

  localparam int unsigned SR_SET_DOM = 0;
  localparam int unsigned SR_RST_DOM = 1;
  localparam int unsigned SR_HOLD    = 2;
  localparam int unsigned SR_TOGGLE  = 3;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int unsigned pop_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One SR channel: registered q with mode-selected conflict resolution and a
// sticky conflict flag.
module sr_cell
  import sr_pkg::*;
#(
  parameter int unsigned MODE = SR_SET_DOM,
  parameter logic        INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic clr_err,
  output logic q,
  output logic conflict
);

  logic q_q, q_d;
  logic conflict_q, conflict_d;
  logic hit;

  assign hit = en & s & r;

  always_comb begin
    q_d = q_q;
    if (en) begin
      unique case ({s, r})
        2'b10: q_d = 1'b1;
        2'b01: q_d = 1'b0;
        2'b11: begin
          unique case (MODE)
            SR_SET_DOM: q_d = 1'b1;
            SR_RST_DOM: q_d = 1'b0;
            SR_TOGGLE:  q_d = ~q_q;
            default:    q_d = q_q;
          endcase
        end
        default: q_d = q_q;
      endcase
    end
  end

  // Clear takes priority over the old flag but not over a conflict this cycle.
  always_comb begin
    conflict_d = clr_err ? hit : (conflict_q | hit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q        <= INIT;
      conflict_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      conflict_q <= conflict_d;
    end
  end

  assign q        = q_q;
  assign conflict = conflict_q;

endmodule

// File: rtl/sr_flop_bank.sv
// Bank of N independent SR channels with sticky conflict flags and a
// saturating count of conflict events.
module sr_flop_bank
  import sr_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned MODE  = SR_SET_DOM,
  parameter logic [N-1:0] INIT = '0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     s,
  input  logic [N-1:0]     r,
  input  logic             clr_err,
  output logic [N-1:0]     q,
  output logic [N-1:0]     qbar,
  output logic [N-1:0]     conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int unsigned PopW = pop_width(N);
  // One spare bit so the add cannot wrap before the saturation check.
  localparam int unsigned SumW = ((CNT_W > PopW) ? CNT_W : PopW) + 1;
  localparam logic [SumW-1:0] CntMax = SumW'((64'd1 << CNT_W) - 64'd1);

  logic [N-1:0]     hit;
  logic [PopW-1:0]  pop;
  logic [SumW-1:0]  base;
  logic [SumW-1:0]  sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar i = 0; i < N; i++) begin : g_cell
    sr_cell #(
      .MODE (MODE),
      .INIT (INIT[i])
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .s        (s[i]),
      .r        (r[i]),
      .clr_err  (clr_err),
      .q        (q[i]),
      .conflict (conflict[i])
    );
  end

  assign hit  = en ? (s & r) : '0;
  assign qbar = ~q;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + PopW'(hit[i]);
    end
  end

  always_comb begin
    base  = clr_err ? '0 : SumW'(cnt_q);
    sum   = base + SumW'(pop);
    cnt_d = (sum > CntMax) ? CntMax[CNT_W-1:0] : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_flop_bank.sv
// Directed bench: four banks (one per MODE) share stimulus; expected values
// are hand-computed constants.
module tb_sr_flop_bank;

  logic       clk = 1'b0;
  logic       rst_n, en, clr_err;
  logic [3:0] s, r;
  logic [3:0] q_m[4], qbar_m[4], conf_m[4], cnt_m[4];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sr_flop_bank #(
      .N     (4),
      .MODE  (g),
      .INIT  (4'b1010),
      .CNT_W (4)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .s            (s),
      .r            (r),
      .clr_err      (clr_err),
      .q            (q_m[g]),
      .qbar         (qbar_m[g]),
      .conflict     (conf_m[g]),
      .conflict_cnt (cnt_m[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr_err = 1'b0; s = '0; r = '0;
    step();
    step();
    check("rst_q0", q_m[0], 4'b1010);
    check("rst_qbar0", qbar_m[0], 4'b0101);
    check("rst_conf0", conf_m[0], 4'b0000);
    check("rst_cnt0", cnt_m[0], 4'd0);
    check("rst_q3", q_m[3], 4'b1010);

    // Release with idle inputs: state holds.
    rst_n = 1'b1; en = 1'b1;
    step();
    check("hold_q0", q_m[0], 4'b1010);
    check("hold_qbar2", qbar_m[2], 4'b0101);

    // Load 0101 through plain set/reset.
    s = 4'b0101; r = 4'b1010;
    step();
    check("load_q1", q_m[1], 4'b0101);

    // One full conflict cycle, every mode.
    s = 4'b1111; r = 4'b1111;
    step();
    check("m0_q", q_m[0], 4'b1111);
    check("m1_q", q_m[1], 4'b0000);
    check("m2_q", q_m[2], 4'b0101);
    check("m3_q", q_m[3], 4'b1010);
    check("m3_qbar", qbar_m[3], 4'b0101);
    check("m0_conf", conf_m[0], 4'b1111);
    check("m2_conf", conf_m[2], 4'b1111);
    check("m0_cnt4", cnt_m[0], 4'd4);
    check("m3_cnt4", cnt_m[3], 4'd4);

    // Saturation.
    step();
    check("cnt8", cnt_m[0], 4'd8);
    check("m3_q_t2", q_m[3], 4'b0101);
    step();
    check("cnt12", cnt_m[0], 4'd12);
    step();
    check("cnt15", cnt_m[0], 4'd15);
    step();
    check("cnt_nowrap", cnt_m[1], 4'd15);
    check("m3_q_t5", q_m[3], 4'b1010);

    // Disabled: inputs ignored, counter frozen.
    en = 1'b0; s = 4'b1111; r = 4'b0000;
    step();
    check("dis_q1", q_m[1], 4'b0000);
    check("dis_cnt", cnt_m[1], 4'd15);
    check("dis_conf", conf_m[1], 4'b1111);
    clr_err = 1'b1;
    step();
    check("dis_clr_conf", conf_m[1], 4'b0000);
    check("dis_clr_cnt", cnt_m[1], 4'd0);
    check("dis_clr_q1", q_m[1], 4'b0000);

    // Clear and new conflict in the same enabled cycle.
    en = 1'b1; s = 4'b0011; r = 4'b0011;
    step();
    check("clr_new_conf", conf_m[0], 4'b0011);
    check("clr_new_cnt", cnt_m[0], 4'd2);
    check("clr_new_q0", q_m[0], 4'b1111);
    check("clr_new_q3", q_m[3], 4'b1001);

    // Build cnt to 9: 4, 6, 8 then +1.
    clr_err = 1'b0;
    step();
    step();
    step();
    check("cnt8b", cnt_m[2], 4'd8);
    s = 4'b0001; r = 4'b0001;
    step();
    check("cnt9", cnt_m[2], 4'd9);

    // Reset mid-streak overrides everything.
    rst_n = 1'b0; s = 4'b1111; r = 4'b1111;
    step();
    check("mid_rst_q0", q_m[0], 4'b1010);
    check("mid_rst_qbar0", qbar_m[0], 4'b0101);
    check("mid_rst_conf", conf_m[2], 4'b0000);
    check("mid_rst_cnt", cnt_m[2], 4'd0);

    // First edge after release acts on sampled inputs.
    rst_n = 1'b1;
    step();
    check("post_rst_q0", q_m[0], 4'b1111);
    check("post_rst_q1", q_m[1], 4'b0000);
    check("post_rst_qbar1", qbar_m[1], 4'b1111);
    check("post_rst_cnt", cnt_m[0], 4'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sr_flop_bank.md
SR_FLOP_BANK -- requirements
Module: sr_flop_bank

Interface
REQ-001 Parameter N, default 4: number of independent SR channels, legal 1..32.
REQ-002 Parameter MODE, default 0: conflict resolution when s and r are both high; 0 set-dominant, 1 reset-dominant, 2 hold, 3 toggle (JK).
REQ-003 Parameter INIT, default all-zero, N bits: per-channel q value loaded at reset.
REQ-004 Parameter CNT_W, default 8: conflict counter width, legal 2..16.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset; synchronous and active-low.
REQ-007 en  input  1  global enable; low freezes all channel state.
REQ-008 s  input  N  per-channel set request.
REQ-009 r  input  N  per-channel reset request.
REQ-010 clr_err  input  1  clears the sticky conflict flags and the conflict counter.
REQ-011 q  output  N  registered channel state.
REQ-012 qbar  output  N  always the bitwise inverse of q, including during and after reset; never equal to q.
REQ-013 conflict  output  N  sticky per-channel flag: s and r were both high while en was high.
REQ-014 conflict_cnt  output  CNT_W  saturating count of channel-conflict events.

Function
REQ-015 Latency: q reflects sampled s and r one clock after the edge at which they are sampled; there is no combinational path from s or r to q.
REQ-016 With en high and s,r = 00, the channel holds its state; 10 sets q to 1; 01 clears q to 0.
REQ-017 With en high and s,r = 11, the next q is given by MODE: 0 gives 1, 1 gives 0, 2 holds the current value, 3 gives the inverse of the current q.
REQ-018 The next q never becomes X or otherwise undefined for any input combination, in any mode.
REQ-019 With en low, q, conflict and conflict_cnt all hold; s, r and conflicts are ignored; clr_err remains effective.
REQ-020 conflict[i] sets on any enabled cycle with s[i]&r[i] and stays set until clr_err or reset.
REQ-021 conflict_cnt adds the number of conflicting channels in each enabled cycle (popcount of s&r, width ceil(log2(N+1))).
REQ-022 conflict_cnt saturates at 2^CNT_W-1 and never wraps.
REQ-023 If clr_err and new conflicts occur in the same cycle, the clear applies first: conflict equals s&r and conflict_cnt equals min(popcount, max).
REQ-024 clr_err does not affect q.

Reset
REQ-025 When rst_n is low at a clock edge: q is loaded with INIT, qbar with ~INIT, conflict with 0 and conflict_cnt with 0.
REQ-026 Reset overrides en, s, r and clr_err, and takes effect at the next clock edge even in the middle of a conflict streak.
REQ-027 The first edge with rst_n high resumes normal operation on the inputs sampled at that edge.

Structure
REQ-028 A shared package sr_pkg holds the MODE encodings as named constants (SR_SET_DOM, SR_RST_DOM, SR_HOLD, SR_TOGGLE) and a popcount width helper.
REQ-029 A sub-module sr_cell implements one channel: next-state and conflict logic for q and its sticky flag, with the MODE and INIT bit passed in as parameters.
REQ-030 sr_flop_bank instantiates N sr_cell copies and owns the adder-tree popcount and the saturating counter.

Verification (N=4, CNT_W=4)
REQ-031 INIT=4'b1010, rst_n low for 2 cycles -> q=1010, qbar=0101, conflict=0, cnt=0; after release with s=r=0, state holds.
REQ-032 MODE=0..3, q=0101, s=r=1111 for one enabled cycle -> q=1111 / 0000 / 0101 / 1010 respectively; conflict=1111 and cnt=4 in every mode.
REQ-033 s=r=1111 for 4 enabled cycles -> cnt saturates at 15 (4, 8, 12, 15) and does not wrap on further conflicts.
REQ-034 en=0 with s=1111, r=0000 -> q unchanged, cnt unchanged; clr_err=1 in the same window -> conflict=0, cnt=0.
REQ-035 clr_err=1 with s=r=0011 in the same enabled cycle -> conflict=0011 and cnt=2 on the next cycle.
REQ-036 rst_n low while s=r=1111 with cnt=9 -> next cycle q=INIT, conflict=0, cnt=0; qbar equals ~q on every cycle.
